gated_reg_bank: RTL

Parametrised, multi-channel successor to the single 15-bit layer-gated register in the binary MLP datapath. Holds `NUM_CH` independent `WIDTH`-bit registers, one per network layer. A per-layer enable models a glitch-free integrated clock gate: only the selected layer's register toggles. Adds in-place shift, a partial low-field clear, per-channel valid flags and saturating load counters, so the layer sequencer can gate, load and inspect each layer's activation word from one block.

---
 rtl/gated_reg_bank_if.sv | 29 ++
 rtl/gated_reg_bank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gated_reg_bank_if.sv
// Control/data bundle for gated_reg_bank: sequencer (master) drives gate/ops/data,
// the bank (slave) returns the per-channel words, valid flags and load counters.
interface gated_reg_bank_if #(
    parameter int WIDTH  = 15,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                    layer_en;
    logic [SEL_W-1:0]        layer_sel;
    logic                    load;
    logic                    shift;
    logic                    clr_lo;
    logic [WIDTH-1:0]        din;
    logic [NUM_CH*WIDTH-1:0] dout;
    logic [NUM_CH-1:0]       dout_vld;
    logic [NUM_CH*CNT_W-1:0] ld_cnt;

    modport master (
        output layer_en, layer_sel, load, shift, clr_lo, din,
        input  dout, dout_vld, ld_cnt
    );

    modport slave (
        input  layer_en, layer_sel, load, shift, clr_lo, din,
        output dout, dout_vld, ld_cnt
    );
endinterface

// File: rtl/gated_reg_bank.sv
// Multi-channel layer-gated register bank: per-channel load/shift under a layer gate,
// ungated low-field clear, valid flags and saturating load counters.
// Define GATED_REG_ICG_EN for a registered (ICG-style, 1-cycle latency) gate.
module gated_reg_ch #(
    parameter int WIDTH   = 15,
    parameter int LO_BITS = 7,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic             i_clr_lo,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q,
    output logic             o_vld,
    output logic [CNT_W-1:0] o_cnt
);
    localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - LO_BITS);

    logic [WIDTH-1:0] r_q;
    logic             r_vld;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_nxt;
    logic             w_ld;

    assign w_ld = i_en && i_load;

    // Clear is applied on top of the gated update so a same-cycle load is also trimmed.
    always_comb begin
        w_nxt = r_q;
        if (w_ld)
            w_nxt = i_din;
        else if (i_en && i_shift)
            w_nxt = r_q << 1;
        if (i_clr_lo)
            w_nxt = w_nxt & ~LO_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            r_vld <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_q <= w_nxt;
            if (w_ld) begin
                r_vld <= 1'b1;
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_q   = r_q;
    assign o_vld = r_vld;
    assign o_cnt = r_cnt;
endmodule

module gated_reg_bank #(
    parameter int WIDTH   = 15,
    parameter int LO_BITS = 7,
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 4
) (
    input logic              clk,
    input logic              rst,
    gated_reg_bank_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]             w_req;
    logic [NUM_CH-1:0]             w_en;
    logic [NUM_CH-1:0][WIDTH-1:0]  w_q;
    logic [NUM_CH-1:0]             w_vld;
    logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt;

    // Out-of-range selects match no channel, so nothing is enabled.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_req
        assign w_req[c] = bus.layer_en && (bus.layer_sel == SEL_W'(c));
    end

`ifdef GATED_REG_ICG_EN
    logic [NUM_CH-1:0] r_en_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_en_q <= '0;
        else
            r_en_q <= w_req;
    end

    assign w_en = r_en_q;
`else
    assign w_en = w_req;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gated_reg_ch #(
            .WIDTH   (WIDTH),
            .LO_BITS (LO_BITS),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_en     (w_en[c]),
            .i_load   (bus.load),
            .i_shift  (bus.shift),
            .i_clr_lo (bus.clr_lo),
            .i_din    (bus.din),
            .o_q      (w_q[c]),
            .o_vld    (w_vld[c]),
            .o_cnt    (w_cnt[c])
        );
    end

    assign bus.dout     = w_q;
    assign bus.dout_vld = w_vld;
    assign bus.ld_cnt   = w_cnt;
endmodule
